usb_tx_framer: RTL and testbench



---
 rtl/usb_tx_framer.sv | 162 ++++++++++++++++
 tb/tb_usb_tx_framer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_framer.sv
// usb_tx_framer: buffers payload words and serialises one framed packet over FT245 write cycles
module usb_tx_framer #(
    parameter int WR_END_CYCLE_TIME         = 25,
    parameter int WR_STROBE_START_TIME      = 5,
    parameter int WR_STROBE_STOP_TIME       = 15,
    parameter int WR_ZZZ_START_TIME         = 2,
    parameter int WR_ZZZ_STOP_TIME          = 22,
    parameter int HEADER_KEY_SYMBOL         = 85,
    parameter int HEADER_KEY_SYMBOL_NUMBER  = 12,
    parameter int TRAILER_KEY_SYMBOL        = 170,
    parameter int TRAILER_KEY_SYMBOL_NUMBER = 8,
    parameter int FIFO_DEPTH                = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        FT_TXEn,
    output logic        FT_WR,
    output logic [7:0]  FT_DATA_Out,
    output logic        FT_DATA_OE,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [15:0] service,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WR_END_CYCLE_TIME + 1);
    localparam logic [CW-1:0] C_END = CW'(WR_END_CYCLE_TIME);
    localparam logic [CW-1:0] C_WS  = CW'(WR_STROBE_START_TIME);
    localparam logic [CW-1:0] C_WE  = CW'(WR_STROBE_STOP_TIME);
    localparam logic [CW-1:0] C_ZS  = CW'(WR_ZZZ_START_TIME);
    localparam logic [CW-1:0] C_ZE  = CW'(WR_ZZZ_STOP_TIME);
    localparam logic [7:0]    H_LAST = 8'(HEADER_KEY_SYMBOL_NUMBER - 1);
    localparam logic [7:0]    T_LAST = 8'(TRAILER_KEY_SYMBOL_NUMBER - 1);

    typedef enum logic [2:0] {IDLE, HEADER, LENGTH, SERVICE, PAYLOAD, TRAILER} state_t;

    state_t         state, state_n;
    logic [15:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    occ;
    logic [15:0]    svc_r, len_r, word_r;
    logic [7:0]     bcnt, byte_v;
    logic [1:0]     txe_s, arm;
    logic [CW-1:0]  cnt;
    logic           act, full, wr_en, send_ok, cyc_end, last, pop, go;

    assign busy       = state != IDLE;
    assign full       = occ == (AW+1)'(FIFO_DEPTH);
    assign word_ready = ~busy & ~full;
    assign wr_en      = word_valid & word_ready;
    assign send_ok    = send & ~busy;
    assign cyc_end    = act & (cnt == C_END);
    assign pop        = cyc_end & (state == PAYLOAD) & bcnt[0];
    assign word_r     = mem[rp];
    // a new byte may follow the previous one on the very next clock, but never past the final trailer byte
    assign go         = arm[1] & ~txe_s[1] & busy & ~(cyc_end & last & (state == TRAILER)) & (~act | cyc_end);
    assign FT_WR      = act & (cnt >= C_WS) & (cnt < C_WE);
    assign FT_DATA_OE = act & (cnt >= C_ZS) & (cnt < C_ZE);

    // packet sequencing: next state, last-byte flag of each field and the byte to send
    always_comb begin
        state_n = state;
        last    = 1'b0;
        byte_v  = 8'h00;
        case (state)
            IDLE:    state_n = send_ok ? HEADER : IDLE;
            HEADER: begin
                last   = bcnt == H_LAST;
                byte_v = 8'(HEADER_KEY_SYMBOL);
                if (cyc_end & last) state_n = LENGTH;
            end
            LENGTH: begin
                last   = bcnt[0];
                byte_v = bcnt[0] ? len_r[7:0] : len_r[15:8];
                if (cyc_end & last) state_n = SERVICE;
            end
            SERVICE: begin
                last   = bcnt[0];
                byte_v = bcnt[0] ? svc_r[7:0] : svc_r[15:8];
                if (cyc_end & last) state_n = (occ == '0) ? TRAILER : PAYLOAD;
            end
            PAYLOAD: begin
                last   = bcnt[0] & (occ == (AW+1)'(1));
                byte_v = bcnt[0] ? word_r[7:0] : word_r[15:8];
                if (cyc_end & last) state_n = TRAILER;
            end
            TRAILER: begin
                last   = bcnt == T_LAST;
                byte_v = 8'(TRAILER_KEY_SYMBOL);
                if (cyc_end & last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, field byte counter, latched packet fields and status flags
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            bcnt     <= '0;
            svc_r    <= '0;
            len_r    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            arm      <= '0;
        end else begin
            state    <= state_n;
            bcnt     <= (cyc_end & last) ? '0 : cyc_end ? bcnt + 8'd1 : bcnt;
            overflow <= send_ok ? 1'b0 : overflow | (word_valid & full & ~busy);
            done     <= cyc_end & last & (state == TRAILER);
            arm      <= busy ? {arm[0], 1'b1} : 2'b00;
            if (send_ok) begin
                svc_r <= service;
                len_r <= 16'(4 + TRAILER_KEY_SYMBOL_NUMBER) + 16'({occ, 1'b0}) + 16'({wr_en, 1'b0});
            end
        end
    end

    // payload FIFO pointers and occupancy; a clear empties the FIFO
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (wr_en) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            if (wr_en & ~pop) occ <= occ + (AW+1)'(1);
            else if (pop & ~wr_en) occ <= occ - (AW+1)'(1);
        end
    end

    // payload storage
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= word_in;
    end

    // TXEn synchroniser and the timed byte write cycle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            txe_s       <= 2'b11;
            act         <= 1'b0;
            cnt         <= '0;
            FT_DATA_Out <= 8'h00;
        end else begin
            txe_s <= {txe_s[0], FT_TXEn};
            if (go) begin
                act <= 1'b1;
                cnt <= '0;
            end else if (cyc_end) begin
                act <= 1'b0;
            end else if (act) begin
                cnt <= cnt + CW'(1);
            end
            if (act & (cnt == '0)) FT_DATA_Out <= byte_v;
        end
    end
endmodule

// File: tb/tb_usb_tx_framer.sv
// tb_usb_tx_framer: table, hand-written and randomized packet checks against a byte-list model
module tb_usb_tx_framer;
    logic        clk = 0, clrn = 1, FT_TXEn = 0, word_valid = 0, send = 0;
    logic        FT_WR, FT_DATA_OE, word_ready, busy, done, overflow;
    logic [7:0]  FT_DATA_Out;
    logic [15:0] word_in = 0, service = 0;

    usb_tx_framer dut (
        .clk(clk), .clrn(clrn), .FT_TXEn(FT_TXEn), .FT_WR(FT_WR), .FT_DATA_Out(FT_DATA_Out),
        .FT_DATA_OE(FT_DATA_OE), .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .service(service), .send(send), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] svc, w0, w1, exp_len;
        int          exp_done;
    } vec_t;

    int          chk = 0, err = 0, tviol = 0, wr_run = 0, oe_run = 0;
    logic        pwr = 0, poe = 0;
    logic [7:0]  d_oe = 0;
    logic [7:0]  cap[$];
    logic [15:0] wq[$];
    vec_t        tbl[5];

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // bus monitor: captures each byte at the falling edge of FT_WR and checks strobe/enable widths and data stability
    always @(negedge clk) begin
        if (!clrn) begin
            wr_run = 0; oe_run = 0; pwr = 0; poe = 0;
        end else begin
            if (FT_WR) wr_run++;
            else if (pwr) begin
                cap.push_back(FT_DATA_Out);
                if (wr_run != 10 || FT_DATA_Out !== d_oe) tviol++;
                wr_run = 0;
            end
            if (FT_DATA_OE) begin
                if (!poe) d_oe = FT_DATA_Out;
                oe_run++;
            end else if (poe) begin
                if (oe_run != 20 || FT_DATA_Out !== d_oe) tviol++;
                oe_run = 0;
            end
            pwr = FT_WR;
            poe = FT_DATA_OE;
        end
    end

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 word_valid = 1; word_in = wq[i];
        end
        @(posedge clk); #1 word_valid = 0;
        @(negedge clk);
    endtask

    task automatic start(input logic [15:0] svc);
        cap.delete();
        tviol = 0;
        @(posedge clk); #1 send = 1; service = svc;
        @(posedge clk); #1 send = 0; service = 16'($urandom);
        @(negedge clk);
        ck("busy_rise", busy, 1);
        ck("ovf_clear", overflow, 0);
    endtask

    task automatic wait_done(input int exp, input bit poke);
        int k = 0;
        while (!done && k < 3000) begin
            @(posedge clk); k++;
            #1;
            if (poke && k < exp - 5 && $urandom_range(0, 39) == 0) begin
                send = 1; word_valid = 1; word_in = 16'($urandom);
            end else begin
                send = 0; word_valid = 0;
            end
            @(negedge clk);
        end
        send = 0; word_valid = 0;
        ck("done_seen", done, 1);
        if (exp >= 0) ck("done_clk", k, exp);
        ck("busy_fall", busy, 0);
        ck("ovf_after_pkt", overflow, 0);
        @(posedge clk); @(negedge clk);
        ck("done_pulse", done, 0);
    endtask

    task automatic check_pkt(input int n, input logic [15:0] svc, input logic [15:0] exp_len);
        logic [7:0]  e[$];
        logic [15:0] len;
        int          m = (n > 16) ? 16 : n;
        len = 16'(12 + 2 * m);
        repeat (12) e.push_back(8'h55);
        e.push_back(len[15:8]); e.push_back(len[7:0]);
        e.push_back(svc[15:8]); e.push_back(svc[7:0]);
        for (int i = 0; i < m; i++) begin
            e.push_back(wq[i][15:8]);
            e.push_back(wq[i][7:0]);
        end
        repeat (8) e.push_back(8'hAA);
        ck("nbytes", cap.size(), e.size());
        for (int i = 0; i < e.size() && i < cap.size(); i++) ck($sformatf("byte%0d", i), cap[i], e[i]);
        ck("len_field", {cap[12], cap[13]}, exp_len);
        ck("wr_oe_timing", tviol, 0);
    endtask

    task automatic run(input vec_t v, input bit poke);
        wq.delete();
        for (int i = 0; i < v.n; i++) wq.push_back(i == 0 ? v.w0 : i == 1 ? v.w1 : 16'($urandom));
        load(v.n);
        ck("ready_after_load", word_ready, v.n < 16);
        ck("ovf_after_load", overflow, v.n > 16);
        start(v.svc);
        wait_done(v.exp_done, poke);
        check_pkt(v.n, v.svc, v.exp_len);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   t, g;
        vec_t v;
        tbl[0] = '{0,  16'h0001, 16'h0000, 16'h0000, 16'h000C, 627};
        tbl[1] = '{2,  16'h0102, 16'h1234, 16'hABCD, 16'h0010, 731};
        tbl[2] = '{17, 16'hBEEF, 16'h0F0F, 16'hF0F0, 16'h002C, 1459};
        tbl[3] = '{16, 16'h8001, 16'hFFFF, 16'h0000, 16'h002C, 1459};
        tbl[4] = '{1,  16'h7E57, 16'hC0DE, 16'h0000, 16'h000E, 679};

        clrn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ck("rst_wr", FT_WR, 0);
        ck("rst_data", FT_DATA_Out, 0);
        ck("rst_oe", FT_DATA_OE, 0);
        ck("rst_ready", word_ready, 1);
        ck("rst_busy", busy, 0);
        ck("rst_done", done, 0);
        ck("rst_ovf", overflow, 0);
        @(posedge clk); #1 clrn = 1;

        for (int i = 0; i < 4; i++) run(tbl[i], 0);

        wq.delete(); wq.push_back(16'($urandom));
        load(1);
        start(16'h5A5A);
        t = 0;
        while (cap.size() < 5 && t < 1000) begin @(negedge clk); t++; end
        FT_TXEn = 1;
        repeat (100) @(negedge clk);
        ck("hold_bytes", cap.size(), 5);
        ck("hold_wr", FT_WR, 0);
        @(posedge clk); #1 FT_TXEn = 0;
        g = 0;
        while (!FT_DATA_OE && g < 50) begin @(posedge clk); g++; @(negedge clk); end
        ck("resume_oe_clk", g, 5);
        wait_done(-1, 0);
        check_pkt(1, 16'h5A5A, 16'h000E);

        for (int r = 0; r < 6; r++) begin
            v.n = $urandom_range(0, 16);
            v.svc = 16'($urandom); v.w0 = 16'($urandom); v.w1 = 16'($urandom);
            v.exp_len = 16'(12 + 2 * v.n);
            v.exp_done = (24 + 2 * v.n) * 26 + 3;
            run(v, 1);
        end
        run(tbl[0], 0);

        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(16'($urandom));
        load(3);
        start(16'h3C3C);
        t = 0;
        while (cap.size() < 18 && t < 1000) begin @(negedge clk); t++; end
        #2 clrn = 0;
        #1;
        ck("clr_wr", FT_WR, 0);
        ck("clr_oe", FT_DATA_OE, 0);
        ck("clr_busy", busy, 0);
        ck("clr_data", FT_DATA_Out, 0);
        ck("clr_ready", word_ready, 1);
        ck("clr_done", done, 0);
        @(posedge clk); #1 clrn = 1;
        run(tbl[4], 0);

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule
